ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device sender: inhibit, start bit, 8 data bits + odd parity + stop on device clock falls, then ack check.
// Latency: acts within 3 clk cycles of a pad falling edge; tx_ready only in IDLE, requests are otherwise ignored.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_HOLD     = 50,
    parameter int FRAME_TIMEOUT  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int MAX_A   = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
    localparam int MAX_CNT = (FRAME_TIMEOUT > MAX_A) ? FRAME_TIMEOUT : MAX_A;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_HOLD - 1);
    localparam logic [CW-1:0] TMO        = CW'(FRAME_TIMEOUT);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    edge_cnt, edge_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          dat_q, dat_d;

    logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic clk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {clk_s1, clk_s2, clk_prev, dat_s1, dat_s2} <= 5'b11111;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
        end
    end

    assign clk_fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            dat_q    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            edge_cnt <= edge_d;
            data_q   <= data_d;
            par_q    <= par_d;
            dat_q    <= dat_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        edge_d     = edge_cnt;
        data_d     = data_q;
        par_d      = par_q;
        dat_d      = dat_q;
        tx_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    data_d  = tx_data;
                    par_d   = ~^tx_data;
                    edge_d  = '0;
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            START: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
                if (cnt == START_LAST) begin
                    cnt_d   = '0;
                    dat_d   = 1'b1;     // start bit stays on the line until the first device fall
                    state_d = SEND;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            SEND: begin
                ps2_dat_oe = dat_q;
                if (cnt == TMO) begin
                    err     = 1'b1;
                    dat_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (clk_fall) begin
                        edge_d = edge_cnt + 4'd1;
                        case (edge_cnt)
                            4'd0, 4'd1, 4'd2, 4'd3,
                            4'd4, 4'd5, 4'd6, 4'd7: dat_d = ~data_q[edge_cnt[2:0]];
                            4'd8:                   dat_d = ~par_q;
                            default: begin
                                dat_d   = 1'b0;
                                state_d = ACK;
                            end
                        endcase
                    end
                end
            end
            ACK: begin
                if (cnt == TMO) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (clk_fall) begin
                        done    = ~dat_s2;
                        err     = dat_s2;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
